// File: rtl/spatial_encoder.sv
// spatial_encoder: binds im/projm pairs, keeps a per-dimension popcount over a frame
// of num_channel pairs, then presents the majority-bundled hypervector downstream.
`ifndef HV_DIMENSION
`define HV_DIMENSION 1024
`endif
module spatial_encoder #(
    parameter int num_channel  = 32,
    parameter int hv_dimension = `HV_DIMENSION,
    parameter int threshold    = num_channel / 2,
    parameter int cnt_width    = $clog2(num_channel + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [hv_dimension-1:0] im,
    input  logic [hv_dimension-1:0] projm,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [hv_dimension-1:0] hvout,
    output logic                    dout_valid,
    input  logic                    dout_ready
);
    typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;
    localparam logic [cnt_width-1:0] thr_val   = cnt_width'(threshold);
    localparam logic [cnt_width-1:0] last_chan = cnt_width'(num_channel - 1);
    state_t               r_state, w_next;
    logic [cnt_width-1:0] r_chan;
    logic [cnt_width-1:0] r_cnt [hv_dimension];
    logic                 w_din_fire, w_dout_fire, w_last;
    assign w_din_fire  = din_valid & din_ready;
    assign w_dout_fire = dout_valid & dout_ready;
    assign w_last      = r_chan == last_chan;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ACCUM;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == ACCUM && w_din_fire && w_last) ? DONE :
                 (r_state == DONE && w_dout_fire)           ? ACCUM : r_state;
    end
    // hvout is gated by state so it reads as zero while a frame is still accumulating
    always_comb begin
        din_ready  = r_state == ACCUM;
        dout_valid = r_state == DONE;
        hvout      = '0;
        for (int d = 0; d < hv_dimension; d++)
            hvout[d] = dout_valid && (r_cnt[d] > thr_val);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_chan <= '0;
        else if (w_din_fire) r_chan <= w_last ? '0 : r_chan + cnt_width'(1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < hv_dimension; d++) r_cnt[d] <= '0;
        end else if (w_dout_fire) begin
            for (int d = 0; d < hv_dimension; d++) r_cnt[d] <= '0;
        end else if (w_din_fire) begin
            for (int d = 0; d < hv_dimension; d++) r_cnt[d] <= r_cnt[d] + cnt_width'(im[d] ^ projm[d]);
        end
    end
endmodule

// File: tb/tb_spatial_encoder.sv
// tb_spatial_encoder: directed frames with known majority results, plus two
// back-to-back gapped random frames checked against a per-bit count model.
module tb_spatial_encoder;
    localparam int D = 16;
    localparam int N = 32;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic [D-1:0] im = '0, projm = '0, hvout;
    logic         din_valid = 1'b0, din_ready, dout_valid, dout_ready = 1'b0;
    int           checks = 0, errors = 0, fires = 0;

    spatial_encoder #(.num_channel(N), .hv_dimension(D)) dut (
        .clk(clk), .rst_n(rst_n), .im(im), .projm(projm), .din_valid(din_valid),
        .din_ready(din_ready), .hvout(hvout), .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (din_valid && din_ready) fires <= fires + 1;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [D-1:0] a, input logic [D-1:0] b);
        din_valid = 1'b1;
        im        = a;
        projm     = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic take(input string tag, input logic [D-1:0] exp);
        int t = 0;
        din_valid = 1'b0;
        while (dout_valid !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk1({tag, "_valid"}, dout_valid, 1'b1);
        chk({tag, "_hv"}, hvout, exp);
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        chk1({tag, "_ready_after"}, din_ready, 1'b1);
        chk1({tag, "_valid_after"}, dout_valid, 1'b0);
        chk({tag, "_hv_after"}, hvout, '0);
    endtask

    task automatic pulse_reset();
        din_valid = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        chk1("rst_async_ready", din_ready, 1'b1);
        chk1("rst_async_valid", dout_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [D-1:0] a, b, exp;
        int           f0;
        int           sc [D];
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("reset_din_ready", din_ready, 1'b1);
        chk1("reset_dout_valid", dout_valid, 1'b0);
        chk("reset_hvout", hvout, '0);

        // all-ones bind; then back-pressure for 10 cycles with junk on the input
        f0 = fires;
        for (int i = 0; i < N - 1; i++) send('0, '1);
        chk1("f1_valid_before_last", dout_valid, 1'b0);
        chk("f1_hv_accum", hvout, '0);
        send('0, '1);
        chk1("f1_latency_valid", dout_valid, 1'b1);
        chk1("f1_done_ready", din_ready, 1'b0);
        chk("f1_hv", hvout, 16'hFFFF);
        din_valid = 1'b1;
        im        = 16'h1234;
        projm     = 16'hFFFF;
        repeat (10) begin
            @(negedge clk);
            chk1("hold_valid", dout_valid, 1'b1);
            chk1("hold_ready", din_ready, 1'b0);
            chk("hold_hv", hvout, 16'hFFFF);
        end
        chk_int("f1_fires", fires - f0, N);
        take("f1", 16'hFFFF);

        for (int i = 0; i < N; i++) begin
            a = D'($urandom);
            send(a, a);
        end
        take("equal", '0);

        // bit 0 bound on 16 channels (tie -> 0), bit 1 on 17 channels (-> 1)
        for (int i = 0; i < N; i++) begin
            b    = '0;
            b[0] = (i < 16);
            b[1] = (i < 17);
            send(16'hA5A5 ^ b, 16'hA5A5);
        end
        take("tie", 16'h0002);

        for (int i = 0; i < 10; i++) send('1, '0);
        pulse_reset();
        for (int i = 0; i < N - 1; i++) send(16'h5A5A, 16'h5A5A);
        chk1("rst_no_chan_residue", dout_valid, 1'b0);
        send(16'h5A5A, 16'h5A5A);
        take("rst_zero", '0);

        // 10 residual ones + 7 new ones would exceed the threshold if not cleared
        for (int i = 0; i < 10; i++) send('1, '0);
        pulse_reset();
        for (int i = 0; i < N; i++) send(i < 7 ? '1 : '0, '0);
        take("rst_counts", '0);

        for (int f = 0; f < 2; f++) begin
            for (int d = 0; d < D; d++) sc[d] = 0;
            f0 = fires;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                a = D'($urandom);
                b = D'($urandom);
                for (int d = 0; d < D; d++) sc[d] += int'(a[d] ^ b[d]);
                send(a, b);
            end
            chk1("rnd_latency_valid", dout_valid, 1'b1);
            for (int d = 0; d < D; d++) exp[d] = sc[d] > N / 2;
            take("rnd", exp);
            chk_int("rnd_fires", fires - f0, N);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
